// File: rtl/prio_pkg.sv
// Shared definitions for the priority interrupt controller and related arbiters.
//   state_e : controller FSM state encoding (IDLE / PRESENT)
//   MAX_N   : largest supported number of request lines
//   clog2   : constant function used to validate index widths
package prio_pkg;

  localparam int MAX_N = 64;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = int'(i) + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/priority_irq_ctrl_if.sv
// Request/grant bundle of the priority interrupt controller.
//   req_in    : raw request lines (polarity set by the controller)
//   mask      : 1 excludes a line from selection
//   irq_ack   : consumer acknowledge of the presented index
//   irq_valid : a request is being presented
//   irq_idx   : index of the presented request
//   pending   : current pending register
//   overrun   : sticky flag, edge seen on an already-pending line
// master = request source / consumer side, slave = controller side.
interface priority_irq_ctrl_if #(
  parameter int N    = 8,
  parameter int IDXW = 3
);
  logic [N-1:0]    req_in;
  logic [N-1:0]    mask;
  logic            irq_ack;
  logic            irq_valid;
  logic [IDXW-1:0] irq_idx;
  logic [N-1:0]    pending;
  logic            overrun;

  modport master (
    output req_in, mask, irq_ack,
    input  irq_valid, irq_idx, pending, overrun
  );

  modport slave (
    input  req_in, mask, irq_ack,
    output irq_valid, irq_idx, pending, overrun
  );
endinterface

// File: rtl/prio_find.sv
// Combinational highest-set-bit finder (generalised casez priority encoder).
//   vec : input vector
//   any : at least one bit of vec is set
//   sel : index of the highest set bit (0 when none)
module prio_find #(
  parameter int N    = 8,
  parameter int IDXW = 3
) (
  input  logic [N-1:0]    vec,
  output logic            any,
  output logic [IDXW-1:0] sel
);

  // Ascending scan: the last set bit seen is the highest one.
  always_comb begin
    any = 1'b0;
    sel = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec[i]) begin
        any = 1'b1;
        sel = IDXW'(i);
      end
    end
  end

endmodule

// File: rtl/priority_irq_ctrl.sv
// Registered priority interrupt controller.
// Captures N request lines (level or edge, selectable polarity) into a
// pending register, masks them, and presents the highest-index candidate
// through a valid/ack handshake. All outputs are registered.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : request/grant bundle (slave modport)
module priority_irq_ctrl
  import prio_pkg::*;
#(
  parameter int N          = 8,
  parameter int IDXW       = 3,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit EDGE_MODE  = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  priority_irq_ctrl_if.slave   bus
);

  if (IDXW != clog2(N) || N < 2 || N > MAX_N) begin : g_bad_param
    $error("priority_irq_ctrl: N must be 2..64 and IDXW must equal clog2(N)");
  end

  logic [N-1:0]    req_q, req_d;
  logic [N-1:0]    req_dly_q, req_dly_d;
  logic [N-1:0]    pending_q, pending_d;
  logic            overrun_q, overrun_d;
  state_e          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;

  logic [N-1:0]    set, clr, cand;
  logic            fire, any;
  logic [IDXW-1:0] sel;

  prio_find #(.N(N), .IDXW(IDXW)) u_find (
    .vec (cand),
    .any (any),
    .sel (sel)
  );

  // Capture and pending datapath; set wins over clear on the same bit.
  always_comb begin
    req_d     = ACTIVE_LOW ? ~bus.req_in : bus.req_in;
    req_dly_d = req_q;
    set       = EDGE_MODE ? (req_q & ~req_dly_q) : req_q;
    fire      = (state_q == ST_PRESENT) && bus.irq_ack;
    clr       = fire ? (N'(1) << idx_q) : '0;
    pending_d = (pending_q & ~clr) | set;
    overrun_d = overrun_q;
    if (|(set & pending_q & ~clr)) overrun_d = 1'b1;
    else if (fire)                 overrun_d = 1'b0;
    cand      = pending_q & ~bus.mask;
  end

  // Grant FSM; the index is latched on entry to PRESENT and held until ack.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (any) begin
          state_d = ST_PRESENT;
          idx_d   = sel;
        end
      end
      ST_PRESENT: begin
        if (bus.irq_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q     <= '0;
      req_dly_q <= '0;
      pending_q <= '0;
      overrun_q <= 1'b0;
      state_q   <= ST_IDLE;
      idx_q     <= '0;
    end else begin
      req_q     <= req_d;
      req_dly_q <= req_dly_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      state_q   <= state_d;
      idx_q     <= idx_d;
    end
  end

  assign bus.irq_valid = (state_q == ST_PRESENT);
  assign bus.irq_idx   = idx_q;
  assign bus.pending   = pending_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_priority_irq_ctrl.sv
// Self-checking bench: a level-mode and an edge-mode controller (N=8,
// active-low) run side by side against a cycle model built from the
// capture/priority rules, plus hand-computed literal expectations.
module tb_priority_irq_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] req  [2];
  logic [7:0] mask [2];
  logic       ack  [2];

  priority_irq_ctrl_if #(.N(8), .IDXW(3)) bl ();
  priority_irq_ctrl_if #(.N(8), .IDXW(3)) be ();

  assign bl.req_in  = req[0];
  assign bl.mask    = mask[0];
  assign bl.irq_ack = ack[0];
  assign be.req_in  = req[1];
  assign be.mask    = mask[1];
  assign be.irq_ack = ack[1];

  priority_irq_ctrl #(.N(8), .IDXW(3), .ACTIVE_LOW(1'b1), .EDGE_MODE(1'b0)) dut_l (
    .clk(clk), .reset(rst), .bus(bl)
  );
  priority_irq_ctrl #(.N(8), .IDXW(3), .ACTIVE_LOW(1'b1), .EDGE_MODE(1'b1)) dut_e (
    .clk(clk), .reset(rst), .bus(be)
  );

  int ncmp = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_act  [2];   // active-high request seen at last edge
  logic [7:0] m_prev [2];   // active-high request seen one edge earlier
  logic [7:0] m_pend [2];
  logic       m_ovr  [2];
  logic       m_val  [2];
  logic [2:0] m_idx  [2];

  always @(posedge clk or posedge rst) begin
    logic [7:0] s, c, cand;
    logic       fire;
    int         hi;
    if (rst) begin
      for (int m = 0; m < 2; m++) begin
        m_act[m] = 8'h00; m_prev[m] = 8'h00; m_pend[m] = 8'h00;
        m_ovr[m] = 1'b0;  m_val[m]  = 1'b0;  m_idx[m]  = 3'd0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        s    = (m == 1) ? (m_act[m] & ~m_prev[m]) : m_act[m];
        fire = m_val[m] && ack[m];
        c    = fire ? (8'h01 << m_idx[m]) : 8'h00;
        cand = m_pend[m] & ~mask[m];
        hi   = -1;
        for (int b = 7; b >= 0; b--) begin
          if (cand[b] && hi < 0) hi = b;
        end
        if (m_val[m]) begin
          if (ack[m]) m_val[m] = 1'b0;
        end else if (hi >= 0) begin
          m_val[m] = 1'b1;
          m_idx[m] = 3'(hi);
        end
        if ((s & m_pend[m] & ~c) != 8'h00) m_ovr[m] = 1'b1;
        else if (fire)                      m_ovr[m] = 1'b0;
        m_pend[m] = (m_pend[m] & ~c) | s;
        m_prev[m] = m_act[m];
        m_act[m]  = ~req[m];
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("lvl_valid",   bl.irq_valid, m_val[0]);
      chk("lvl_pending", bl.pending,   m_pend[0]);
      chk("lvl_overrun", bl.overrun,   m_ovr[0]);
      if (m_val[0]) chk("lvl_idx", bl.irq_idx, m_idx[0]);
      chk("edg_valid",   be.irq_valid, m_val[1]);
      chk("edg_pending", be.pending,   m_pend[1]);
      chk("edg_overrun", be.overrun,   m_ovr[1]);
      if (m_val[1]) chk("edg_idx", be.irq_idx, m_idx[1]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    for (int m = 0; m < 2; m++) begin
      req[m] = 8'hFF; mask[m] = 8'h00; ack[m] = 1'b0;
    end
    #17 rst = 1'b0;

    // All lines inactive after reset: nothing pends, nothing presented.
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("rst_idle_valid", bl.irq_valid, 1'b0);
    end
    chk("rst_idle_pend", bl.pending, 8'h00);

    // Line 5: pending at k+1, presented at k+2, ack clears.
    req[0] = 8'hDF;
    tick(); tick();
    chk("l5_pend", bl.pending, 8'h20);
    chk("l5_not_yet_valid", bl.irq_valid, 1'b0);
    req[0] = 8'hFF;
    tick();
    chk("l5_valid", bl.irq_valid, 1'b1);
    chk("l5_idx", bl.irq_idx, 3'd5);
    chk("l5_lvl_overrun", bl.overrun, 1'b1);
    ack[0] = 1'b1;
    tick();
    ack[0] = 1'b0;
    chk("l5_ack_pend", bl.pending, 8'h00);
    chk("l5_ack_valid", bl.irq_valid, 1'b0);
    chk("l5_ack_overrun", bl.overrun, 1'b0);

    // Lines 2 and 6: 6 first, then 2 after one idle cycle.
    req[0] = 8'hBB;
    tick(); tick();
    req[0] = 8'hFF;
    tick();
    chk("p6_idx", bl.irq_idx, 3'd6);
    chk("p6_pend", bl.pending, 8'h44);
    ack[0] = 1'b1; tick(); ack[0] = 1'b0;
    chk("p6_gap_valid", bl.irq_valid, 1'b0);
    chk("p6_gap_pend", bl.pending, 8'h04);
    tick();
    chk("p2_valid", bl.irq_valid, 1'b1);
    chk("p2_idx", bl.irq_idx, 3'd2);
    ack[0] = 1'b1; tick(); ack[0] = 1'b0;
    chk("p2_done_pend", bl.pending, 8'h00);
    tick();
    chk("p2_done_valid", bl.irq_valid, 1'b0);

    // Mask line 6: only 2 is presented, 6 stays pending.
    mask[0] = 8'h40;
    req[0] = 8'hBB;
    tick(); tick();
    req[0] = 8'hFF;
    tick();
    chk("m_idx", bl.irq_idx, 3'd2);
    ack[0] = 1'b1; tick(); ack[0] = 1'b0;
    tick(); tick();
    chk("m_valid", bl.irq_valid, 1'b0);
    chk("m_pend6", bl.pending, 8'h40);

    // Higher-priority arrival while presenting: index held.
    req[0] = 8'hFB;
    tick(); tick();
    req[0] = 8'hFF;
    tick();
    chk("hold_idx0", bl.irq_idx, 3'd2);
    req[0] = 8'h7F;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_idx", bl.irq_idx, 3'd2);
      chk("hold_valid", bl.irq_valid, 1'b1);
    end
    chk("hold_pend", bl.pending, 8'hC4);
    req[0] = 8'hFF;
    ack[0] = 1'b1; tick(); ack[0] = 1'b0;
    chk("hold_ack_pend", bl.pending, 8'hC0);
    tick();
    chk("next7_idx", bl.irq_idx, 3'd7);
    ack[0] = 1'b1; tick(); ack[0] = 1'b0;
    chk("next7_pend", bl.pending, 8'h40);
    mask[0] = 8'h00;
    tick();
    chk("unmask6_idx", bl.irq_idx, 3'd6);
    ack[0] = 1'b1; tick(); ack[0] = 1'b0;
    chk("unmask6_pend", bl.pending, 8'h00);

    // Edge mode: two pulses on line 3 without ack -> overrun.
    req[1] = 8'hF7; tick();
    req[1] = 8'hFF; tick();
    chk("e_pend", be.pending, 8'h08);
    req[1] = 8'hF7; tick();
    chk("e_valid", be.irq_valid, 1'b1);
    chk("e_idx", be.irq_idx, 3'd3);
    chk("e_no_ovr_yet", be.overrun, 1'b0);
    req[1] = 8'hFF; tick();
    chk("e_ovr", be.overrun, 1'b1);
    chk("e_ovr_pend", be.pending, 8'h08);
    ack[1] = 1'b1; tick(); ack[1] = 1'b0;
    chk("e_ack_pend", be.pending, 8'h00);
    chk("e_ack_ovr", be.overrun, 1'b0);

    // Edge mode, line held: one capture, no re-pend after ack.
    req[1] = 8'hF7;
    tick(); tick(); tick();
    chk("eh_idx", be.irq_idx, 3'd3);
    ack[1] = 1'b1; tick(); ack[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("eh_no_repend", be.pending, 8'h00);
      chk("eh_no_valid", be.irq_valid, 1'b0);
    end
    req[1] = 8'hFF;
    tick(); tick();

    // Asynchronous reset in the middle of PRESENT.
    req[0] = 8'hDF; req[1] = 8'hFD;
    tick();
    req[1] = 8'hFF;
    tick(); tick(); tick();
    chk("ar_pre_valid_l", bl.irq_valid, 1'b1);
    chk("ar_pre_ovr_l", bl.overrun, 1'b1);
    chk("ar_pre_valid_e", be.irq_valid, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("ar_valid_l", bl.irq_valid, 1'b0);
    chk("ar_pend_l", bl.pending, 8'h00);
    chk("ar_ovr_l", bl.overrun, 1'b0);
    chk("ar_valid_e", be.irq_valid, 1'b0);
    chk("ar_pend_e", be.pending, 8'h00);
    req[0] = 8'hFF;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ar_after_valid", bl.irq_valid, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
